// File: rtl/calc_pkg.sv
//------------------------------------------------------------------------------
// Module   : calc_pkg
// Purpose  : Button indices and sizing helpers shared by the calculator blocks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

    localparam int BTN_ENTER = 0;
    localparam int BTN_BACK  = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int NUM_BTNS  = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
//------------------------------------------------------------------------------
// Module   : debounce_channel
// Purpose  : One button: 2-flop sync, debounce, press pulse, optional repeat.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module debounce_channel
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_pulse;

    logic w_diff;
    logic w_accept;
    logic w_rise;
    logic w_fall;

    assign w_diff   = (r_s2 != r_level);
    assign w_accept = w_diff && (r_cnt == C_DB_LAST);
    assign w_rise   = w_accept && r_s2;
    assign w_fall   = w_accept && !r_s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            if (!w_diff || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept) begin
                r_level <= r_s2;
            end
        end
    end

    generate
        if (REPEAT_EN) begin : g_rep
            localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
            localparam logic [RW-1:0] C_RPT_DELAY  = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] C_RPT_PERIOD = RW'(REPEAT_PERIOD - 1);

            logic [RW-1:0] r_rcnt;

            // The falling edge of the level also kills a repeat due on that edge.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rcnt  <= '0;
                    r_pulse <= 1'b0;
                end else if (w_rise) begin
                    r_rcnt  <= C_RPT_DELAY;
                    r_pulse <= 1'b1;
                end else if (!r_level || w_fall) begin
                    r_rcnt  <= '0;
                    r_pulse <= 1'b0;
                end else if (r_rcnt != '0) begin
                    r_rcnt  <= r_rcnt - RW'(1);
                    r_pulse <= 1'b0;
                end else begin
                    r_rcnt  <= C_RPT_PERIOD;
                    r_pulse <= 1'b1;
                end
            end
        end else begin : g_norep
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_pulse <= 1'b0;
                end else begin
                    r_pulse <= w_rise;
                end
            end
        end
    endgenerate

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
//------------------------------------------------------------------------------
// Module   : button_conditioner
// Purpose  : Sync/debounce/pulse front end for the four calculator buttons.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_conditioner
    import calc_pkg::*;
#(
    parameter int                  DEBOUNCE_CYCLES = 50000,
    parameter int                  REPEAT_DELAY    = 25000000,
    parameter int                  REPEAT_PERIOD   = 5000000,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = 4'b1100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_pulse
);

    generate
        for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_EN       (REPEAT_MASK[i])
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .i_btn   (btn_in[i]),
                .o_level (btn_level[i]),
                .o_pulse (btn_pulse[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
//------------------------------------------------------------------------------
// Module   : tb_button_conditioner
// Purpose  : Scoreboard bench for button_conditioner (D=4, delay=10, period=3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_conditioner;
    import calc_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;

    int   ecount   = 0;
    logic rst_seen = 1'b0;
    int   npass    = 0;
    int   ntotal   = 0;
    exp_t q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .REPEAT_MASK     (4'b1100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        ecount   <= ecount + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecount, act, exp);
    endtask

    function automatic void push_exp(input int c, input logic [3:0] m);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc == c) begin
                q[i].pulse = q[i].pulse | m;
                return;
            end
            if (q[i].cyc > c) begin
                q.insert(i, '{c, m});
                return;
            end
        end
        q.push_back('{c, m});
    endfunction

    function automatic void flush_after(input int k);
        while (q.size() > 0 && q[q.size()-1].cyc > k) q.delete(q.size() - 1);
    endfunction

    // Monitor: every nonzero pulse, or any due expectation, consumes one entry.
    always @(negedge clk) begin
        if (ecount > 0) begin
            if (!rst_seen) begin
                chk("reset_outputs", {24'd0, btn_level, btn_pulse}, 32'd0);
            end else if (btn_pulse != 4'd0 || (q.size() > 0 && q[0].cyc <= ecount)) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {28'd0, btn_pulse}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_cycle", ecount, e.cyc);
                    chk("pulse_value", {28'd0, btn_pulse}, {28'd0, e.pulse});
                end
            end
        end
    end

    task automatic go(input int c);
        while (ecount < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int t, p, r, k;
        rst    = 1'b0;
        btn_in = 4'hF;
        go(5);

        // Reset release with all buttons held
        t = ecount;
        rst = 1'b1;
        p = t + 6;
        push_exp(p, 4'hF);
        go(p - 1); chk("rst_level_before", {28'd0, btn_level}, 32'h0);
        go(p);     chk("rst_level_after", {28'd0, btn_level}, 32'hF);
        go(p + 2); btn_in = 4'h0; r = ecount;
        go(r + 5); chk("rst_rel_level_hold", {28'd0, btn_level}, 32'hF);
        go(r + 6); chk("rst_rel_level_fall", {28'd0, btn_level}, 32'h0);
        go(r + 10);

        // Clean press of enter
        t = ecount;
        btn_in[BTN_ENTER] = 1'b1;
        push_exp(t + 6, 4'b0001);
        go(t + 5);  chk("enter_level_before", {28'd0, btn_level}, 32'h0);
        go(t + 6);  chk("enter_level_after", {28'd0, btn_level}, 32'h1);
        go(t + 30); btn_in[BTN_ENTER] = 1'b0; r = ecount;
        go(r + 5);  chk("enter_rel_hold", {28'd0, btn_level}, 32'h1);
        go(r + 6);  chk("enter_rel_fall", {28'd0, btn_level}, 32'h0);
        go(r + 10);

        // Two 3-cycle glitches on up: level must not move
        for (int g = 0; g < 2; g++) begin
            t = ecount;
            btn_in[BTN_UP] = 1'b1;
            go(t + 3); btn_in[BTN_UP] = 1'b0;
            go(t + 10);
        end
        chk("glitch_level", {28'd0, btn_level}, 32'h0);

        // Bounce 1,0,1,0 every 2 cycles, then stable 1
        t = ecount;
        for (int b = 0; b < 4; b++) begin
            btn_in[BTN_UP] = ~b[0];
            go(t + 2 * (b + 1));
        end
        btn_in[BTN_UP] = 1'b1;
        p = ecount + 6;
        push_exp(p, 4'b0100);
        go(p + 3); btn_in[BTN_UP] = 1'b0; r = ecount;
        go(r + 5); chk("bounce_level_hold", {28'd0, btn_level}, 32'h4);
        go(r + 6); chk("bounce_level_fall", {28'd0, btn_level}, 32'h0);
        go(r + 10);

        // Auto-repeat on up; release so the fall lands on a repeat edge
        t = ecount;
        btn_in[BTN_UP] = 1'b1;
        p = t + 6;
        r = p + 25;
        push_exp(p, 4'b0100);
        for (int c = p + 10; c <= r + 5; c += 3) push_exp(c, 4'b0100);
        go(r); btn_in[BTN_UP] = 1'b0;
        go(r + 6); chk("rpt_level_fall", {28'd0, btn_level}, 32'h0);
        go(r + 12);

        // Enter and down together: both pulse, only down repeats
        t = ecount;
        btn_in = 4'b1001;
        p = t + 6;
        r = p + 16;
        push_exp(p, 4'b1001);
        for (int c = p + 10; c <= r + 5; c += 3) push_exp(c, 4'b1000);
        go(p); chk("simul_level", {28'd0, btn_level}, 32'h9);
        go(r); btn_in = 4'b0000;
        go(r + 12);

        // Reset while up is repeating, button kept held across reset
        t = ecount;
        btn_in[BTN_UP] = 1'b1;
        p = t + 6;
        push_exp(p, 4'b0100);
        push_exp(p + 10, 4'b0100);
        push_exp(p + 13, 4'b0100);
        go(p + 14);
        k = ecount;
        rst = 1'b0;
        flush_after(k);
        go(k + 1); chk("midrst_level", {28'd0, btn_level}, 32'h0);
        go(k + 3);
        t = ecount;
        rst = 1'b1;
        p = t + 6;
        r = p + 12;
        push_exp(p, 4'b0100);
        for (int c = p + 10; c <= r + 5; c += 3) push_exp(c, 4'b0100);
        go(p - 1); chk("midrst_relevel_before", {28'd0, btn_level}, 32'h0);
        go(p);     chk("midrst_relevel_after", {28'd0, btn_level}, 32'h4);
        go(r); btn_in[BTN_UP] = 1'b0;
        go(r + 20);

        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

`default_nettype wire
